// File: rtl/inpmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inpmem_ctrl_pkg
//  Brief    : Shared state encodings and SRAM control levels for inpmem_ctrl.
//  Revision : 1.0
// ============================================================================
package inpmem_ctrl_pkg;

    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_STREAM = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN  = 2'd2;

    // SRAM strobes are active low
    localparam logic c_CEN_ON  = 1'b0;
    localparam logic c_CEN_OFF = 1'b1;
    localparam logic c_WEN_WR  = 1'b0;
    localparam logic c_WEN_RD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/inpmem_skid.sv
`default_nettype none
// ============================================================================
//  Module   : inpmem_skid
//  Brief    : 2-entry FIFO that catches SRAM read returns ahead of the feeder.
//  Revision : 1.0
// ============================================================================
module inpmem_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_cnt;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_head  = r_mem[r_rp];

    assign w_pop  = i_pop & ~o_empty;
    // A pop frees the head slot in the same cycle, so a full FIFO may still accept
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) r_wp <= ~r_wp;
            if (w_pop)  r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/inpmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inpmem_ctrl
//  Brief    : Input SRAM sequencer: host write arbitration and burst streaming.
//  Revision : 1.0
// ============================================================================
module inpmem_ctrl
    import inpmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [LEN_W-1:0]     r_remain;
    logic [1:0]           r_credit;
    logic                 r_wr_ready;
    logic                 r_zero_done;
    logic                 r_ret;
    logic                 r_mem_cen;
    logic                 r_mem_wen;
    logic [ADDR_W-1:0]    r_mem_a;
    logic [DATA_W-1:0]    r_mem_d;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_can_issue;
    logic                 w_write;
    logic                 w_issue;
    logic                 w_load;
    logic                 w_zero;
    logic                 w_last_pop;
    logic                 w_empty;
    logic                 w_full;
    logic [ADDR_W-1:0]    w_issue_addr;

    // Credits count reads issued but not yet consumed; a same-cycle pop frees one
    assign w_pop        = out_valid & out_ready;
    assign w_can_issue  = (r_credit < 2'd2) | w_pop;
    assign w_push       = r_ret & (~w_full | w_pop);
    assign w_last_pop   = (r_state == c_ST_DRAIN) & w_pop & (r_credit == 2'd1);
    assign w_issue_addr = (r_state == c_ST_IDLE) ? base_addr : r_rd_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_zero      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_wr_ready) begin
                    if (wr_valid) begin
                        w_write = 1'b1;
                    end else if (start) begin
                        if (len == '0) begin
                            w_zero = 1'b1;
                        end else begin
                            // First read goes out on the start decision itself
                            w_load      = 1'b1;
                            w_issue     = 1'b1;
                            w_state_nxt = (len == LEN_W'(1)) ? c_ST_DRAIN : c_ST_STREAM;
                        end
                    end
                end
            end
            c_ST_STREAM: begin
                if (w_can_issue) begin
                    w_issue = 1'b1;
                    if (r_remain == LEN_W'(1)) w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_last_pop) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_wr_ready  <= 1'b0;
            r_zero_done <= 1'b0;
            r_ret       <= 1'b0;
            r_credit    <= 2'd0;
            r_rd_addr   <= '0;
            r_remain    <= '0;
            r_mem_cen   <= c_CEN_OFF;
            r_mem_wen   <= c_WEN_RD;
            r_mem_a     <= '0;
            r_mem_d     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ready  <= (w_state_nxt == c_ST_IDLE);
            r_zero_done <= w_zero;
            r_ret       <= (r_mem_cen == c_CEN_ON) && (r_mem_wen == c_WEN_RD);
            r_credit    <= r_credit + {1'b0, w_issue} - {1'b0, w_pop};

            if (w_load) begin
                r_rd_addr <= base_addr + ADDR_W'(1);
                r_remain  <= len - LEN_W'(1);
            end else if (w_issue) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
                r_remain  <= r_remain - LEN_W'(1);
            end

            if (w_write) begin
                r_mem_cen <= c_CEN_ON;
                r_mem_wen <= c_WEN_WR;
                r_mem_a   <= wr_addr;
                r_mem_d   <= wr_data;
            end else if (w_issue) begin
                r_mem_cen <= c_CEN_ON;
                r_mem_wen <= c_WEN_RD;
                r_mem_a   <= w_issue_addr;
            end else begin
                r_mem_cen <= c_CEN_OFF;
                r_mem_wen <= c_WEN_RD;
            end
        end
    end

    inpmem_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (mem_q),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (out_data)
    );

    assign out_valid = ~w_empty;
    assign wr_ready  = r_wr_ready;
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_zero_done | w_last_pop;
    assign mem_cen   = r_mem_cen;
    assign mem_wen   = r_mem_wen;
    assign mem_a     = r_mem_a;
    assign mem_d     = r_mem_d;

endmodule
`default_nettype wire
